// File: rtl/draw_rect_pkg.sv
// Shared definitions for the draw_rect rectangle controllers: position width,
// default geometry and the controller state encoding.
package draw_rect_pkg;

    localparam int POS_W = 12;

    localparam int SCREEN_WIDTH_DEF  = 800;
    localparam int SCREEN_HEIGHT_DEF = 600;
    localparam int RECT_WIDTH_DEF    = 48;
    localparam int RECT_HEIGHT_DEF   = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_FALL = 2'd2;
    localparam logic [1:0] ST_REST = 2'd3;

    typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/draw_rect_tick.sv
// Physics tick generator: counts 0..TICK_DIV-1 while enabled and pulses tick
// on the last count; clr forces the count back to zero.
module draw_rect_tick #(
    parameter int TICK_DIV = 65000
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt == CNT_LAST);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/draw_rect_phys_ctl.sv
// Rectangle position controller: follows the mouse while held, then falls under
// fixed-point gravity with optional lossy floor bounce, and rests until grabbed.
module draw_rect_phys_ctl
    import draw_rect_pkg::*;
#(
    parameter int SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT  = SCREEN_HEIGHT_DEF,
    parameter int RECT_WIDTH     = RECT_WIDTH_DEF,
    parameter int RECT_HEIGHT    = RECT_HEIGHT_DEF,
    parameter int FRAC_BITS      = 4,
    parameter int TICK_DIV       = 65000,
    parameter int GRAVITY        = 16,
    parameter int VMAX           = 1024,
    parameter int BOUNCE_EN      = 1,
    parameter int BOUNCE_SHIFT   = 1,
    parameter int MIN_BOUNCE_VEL = 32
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             mouse_left,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic [1:0]       state,
    output logic             landed,
    output logic             bounced
);

    localparam int XMAX  = SCREEN_WIDTH - RECT_WIDTH;
    localparam int FLOOR = SCREEN_HEIGHT - RECT_HEIGHT;
    // Fixed-point y plus a sign bit and one guard bit for the y + v sum.
    localparam int YW    = POS_W + FRAC_BITS + 2;

    localparam pos_t XMAX_P = POS_W'(XMAX);
    localparam pos_t FLOOR_P = POS_W'(FLOOR);
    localparam logic signed [YW-1:0] FLOOR_FP = YW'(FLOOR * (2 ** FRAC_BITS));
    localparam logic signed [YW-1:0] GRAV_S   = YW'(GRAVITY);
    localparam logic signed [YW-1:0] VMAX_S   = YW'(VMAX);
    localparam logic signed [YW-1:0] MINB_S   = YW'(MIN_BOUNCE_VEL);

    function automatic logic signed [YW-1:0] sat_vmax(input logic signed [YW-1:0] v);
        return (v > VMAX_S) ? VMAX_S : v;
    endfunction

    function automatic logic signed [YW-1:0] bounce_vel(input logic signed [YW-1:0] v);
        return -(v - (v >>> BOUNCE_SHIFT));
    endfunction

    pos_t cx, cy;
    logic signed [YW-1:0] y_fp, vel;
    logic signed [YW-1:0] vn, yn, y_nx, v_nx;
    logic hit_floor, do_bounce, tick, tick_clr;

    assign cx = (mouse_xpos > XMAX_P) ? XMAX_P : mouse_xpos;
    assign cy = (mouse_ypos > FLOOR_P) ? FLOOR_P : mouse_ypos;

    // A grab during FALL clears the counter and suppresses the tick in the same cycle.
    assign tick_clr = (state != ST_FALL) || mouse_left;

    draw_rect_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .pclk  (pclk),
        .rst_n (rst_n),
        .en    (state == ST_FALL),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        vn        = sat_vmax(vel + GRAV_S);
        yn        = y_fp + vn;
        hit_floor = (yn >= FLOOR_FP);
        do_bounce = hit_floor && (BOUNCE_EN != 0) && (vn > MINB_S);
        y_nx      = yn;
        v_nx      = vn;
        if (hit_floor) begin
            y_nx = FLOOR_FP;
            v_nx = do_bounce ? bounce_vel(vn) : '0;
        end else if (yn < 0) begin
            y_nx = '0;
            v_nx = '0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            xpos    <= '0;
            ypos    <= '0;
            y_fp    <= '0;
            vel     <= '0;
            landed  <= 1'b0;
            bounced <= 1'b0;
        end else begin
            landed  <= 1'b0;
            bounced <= 1'b0;
            case (state)
                ST_IDLE: begin
                    xpos <= cx;
                    ypos <= cy;
                    vel  <= '0;
                    if (mouse_left) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    vel <= '0;
                    if (mouse_left) begin
                        xpos <= cx;
                        ypos <= cy;
                    end else begin
                        state <= ST_FALL;
                        y_fp  <= {2'b00, ypos, {FRAC_BITS{1'b0}}};
                    end
                end
                ST_FALL: begin
                    if (mouse_left) begin
                        state <= ST_HOLD;
                        vel   <= '0;
                    end else if (tick) begin
                        y_fp <= y_nx;
                        vel  <= v_nx;
                        ypos <= y_nx[FRAC_BITS +: POS_W];
                        if (do_bounce) begin
                            bounced <= 1'b1;
                        end else if (hit_floor) begin
                            landed <= 1'b1;
                            state  <= ST_REST;
                        end
                    end
                end
                ST_REST: begin
                    if (mouse_left) state <= ST_HOLD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_rect_phys_ctl.sv
// Bench for draw_rect_phys_ctl: a non-bouncing and a bouncing instance share
// stimulus and are compared every cycle against a tick-level reference model.
module tb_draw_rect_phys_ctl;

    localparam int TD    = 4;
    localparam int XMAX  = 800 - 48;
    localparam int FLOOR = 600 - 64;
    localparam int FS    = 16;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        mouse_left;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic [11:0] xpos [2];
    logic [11:0] ypos [2];
    logic [1:0]  state [2];
    logic        landed [2];
    logic        bounced [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = no bounce, 1 = bounce.
    int m_mode [2], m_x [2], m_y [2], m_yfp [2], m_v [2], m_age [2];
    int m_lnd [2], m_bnc [2];

    always #5 pclk = ~pclk;

    draw_rect_phys_ctl #(.TICK_DIV(TD), .BOUNCE_EN(0)) dut_nb (
        .pclk(pclk), .rst_n(rst_n), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .xpos(xpos[0]), .ypos(ypos[0]), .state(state[0]),
        .landed(landed[0]), .bounced(bounced[0])
    );

    draw_rect_phys_ctl #(.TICK_DIV(TD), .BOUNCE_EN(1)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .xpos(xpos[1]), .ypos(ypos[1]), .state(state[1]),
        .landed(landed[1]), .bounced(bounced[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_mode[b] = 0; m_x[b] = 0; m_y[b] = 0; m_yfp[b] = 0;
            m_v[b] = 0; m_age[b] = 0; m_lnd[b] = 0; m_bnc[b] = 0;
        end
    endtask

    // One gravity tick in pixel*16 units, straight from the motion rules.
    task automatic model_tick(input int b);
        int vn, yn;
        vn = m_v[b] + 16;
        if (vn > 1024) vn = 1024;
        yn = m_yfp[b] + vn;
        if (yn >= FLOOR * FS) begin
            m_yfp[b] = FLOOR * FS;
            if (b == 1 && vn > 32) begin
                m_v[b] = -(vn - vn / 2);
                m_bnc[b] = 1;
            end else begin
                m_v[b] = 0;
                m_lnd[b] = 1;
                m_mode[b] = 3;
            end
        end else if (yn < 0) begin
            m_yfp[b] = 0;
            m_v[b] = 0;
        end else begin
            m_yfp[b] = yn;
            m_v[b] = vn;
        end
        m_y[b] = m_yfp[b] / FS;
    endtask

    task automatic model_update();
        int cx, cy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cx = (int'(mouse_xpos) > XMAX) ? XMAX : int'(mouse_xpos);
        cy = (int'(mouse_ypos) > FLOOR) ? FLOOR : int'(mouse_ypos);
        for (int b = 0; b < 2; b++) begin
            m_lnd[b] = 0;
            m_bnc[b] = 0;
            case (m_mode[b])
                0: begin
                    m_x[b] = cx; m_y[b] = cy;
                    if (mouse_left) m_mode[b] = 1;
                end
                1: begin
                    if (mouse_left) begin
                        m_x[b] = cx; m_y[b] = cy;
                    end else begin
                        m_mode[b] = 2; m_yfp[b] = m_y[b] * FS; m_v[b] = 0; m_age[b] = 0;
                    end
                end
                2: begin
                    if (mouse_left) begin
                        m_mode[b] = 1; m_v[b] = 0;
                    end else begin
                        m_age[b]++;
                        if (m_age[b] % TD == 0) model_tick(b);
                    end
                end
                default: if (mouse_left) m_mode[b] = 1;
            endcase
        end
    endtask

    task automatic compare();
        for (int b = 0; b < 2; b++) begin
            check($sformatf("xpos[%0d]", b), int'(xpos[b]), m_x[b]);
            check($sformatf("ypos[%0d]", b), int'(ypos[b]), m_y[b]);
            check($sformatf("state[%0d]", b), int'(state[b]), m_mode[b]);
            check($sformatf("landed[%0d]", b), int'(landed[b]), m_lnd[b]);
            check($sformatf("bounced[%0d]", b), int'(bounced[b]), m_bnc[b]);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge pclk);
        #1;
        compare();
    endtask

    task automatic set_mouse(input int x, input int y, input logic l);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = l;
    endtask

    initial begin
        int k, land_k, nbounce;
        rst_n = 1'b0;
        set_mouse(0, 0, 1'b0);
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;

        // Clamp and follow in IDLE
        set_mouse(790, 590, 1'b0);
        step();
        check("clamp_x", int'(xpos[0]), 752);
        check("clamp_y", int'(ypos[0]), 536);
        set_mouse(100, 200, 1'b0);
        step();
        check("follow_x", int'(xpos[0]), 100);
        check("follow_y", int'(ypos[0]), 200);

        // Drop from the top; watch landing time and bounces
        set_mouse(100, 0, 1'b1);
        repeat (3) step();
        mouse_left = 1'b0;
        step();
        check("fall_entry", int'(state[0]), 2);
        k = 0; land_k = -1; nbounce = 0;
        while ((state[0] != 2'd3 || state[1] != 2'd3) && k < 5000) begin
            step();
            k++;
            if (landed[0] && land_k < 0) land_k = k;
            if (k == 32 * TD) check("y_tick32", int'(ypos[0]), 528);
            if (bounced[1]) nbounce++;
        end
        if (k >= 5000) check("rest_timeout", k, 0);
        check("land_cycle", land_k, 33 * TD);
        check("land_y", int'(ypos[0]), FLOOR);
        check("land_x", int'(xpos[0]), 100);
        check("bounce_seen", int'(nbounce > 1), 1);
        check("bounce_rest_y", int'(ypos[1]), FLOOR);

        // REST ignores mouse movement
        for (int i = 0; i < 1000; i++) begin
            set_mouse($urandom_range(0, 1000), $urandom_range(0, 1000), 1'b0);
            step();
        end
        check("rest_hold_x", int'(xpos[1]), 100);
        check("rest_hold_y", int'(ypos[1]), FLOOR);

        // Grab from REST, then drop and grab mid-air at tick 10
        set_mouse(100, 0, 1'b1);
        repeat (3) step();
        check("grab_state", int'(state[0]), 1);
        mouse_left = 1'b0;
        step();
        repeat (10 * TD) step();
        check("tick10_y", int'(ypos[0]), 55);
        set_mouse(300, 100, 1'b1);
        step();
        check("midair_state", int'(state[0]), 1);
        step();
        check("midair_x", int'(xpos[0]), 300);
        check("midair_y", int'(ypos[0]), 100);
        mouse_left = 1'b0;
        repeat (3 * TD + 1) step();

        // Asynchronous reset mid-fall
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        step();
        rst_n = 1'b1;
        step();

        // Random press/release sessions
        for (int s = 0; s < 40; s++) begin
            int dur;
            set_mouse($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1);
            dur = $urandom_range(1, 20);
            for (int i = 0; i < dur; i++) begin
                set_mouse($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1);
                step();
            end
            mouse_left = 1'b0;
            dur = $urandom_range(1, 300);
            for (int i = 0; i < dur; i++) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
